// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul tile engine.
// - state_e   : engine FSM states
// - acc_width : default accumulator width (product width plus K growth bits)
// - elem_lsb  : LSB of element idx inside a packed vector of w-bit elements
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Enough headroom that K_MAX full-scale products never overflow.
    function automatic int acc_width(input int data_width, input int k_max);
        return 2 * data_width + $clog2(k_max);
    endfunction

    // Element idx of a packed vector lives at [idx*w +: w].
    function automatic int elem_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mac_cell.sv
// One multiply-accumulate element of the tile.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (clears acc)
//   clr          : synchronous clear of acc (wins over en)
//   en           : add a*b into acc this cycle
//   signed_mode  : 1 = operands are two's complement, 0 = unsigned
//   a, b         : DATA_WIDTH operands
//   acc          : ACC_WIDTH running sum, wraps modulo 2^ACC_WIDTH
module mac_cell #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 38
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        a_ext_s;
    logic [PW-1:0]        b_ext_s;
    logic [PW-1:0]        prod_s;
    logic [ACC_WIDTH-1:0] prod_ext_s;

    // Extend operands to product width first, so one unsigned multiply
    // truncated to PW bits yields the correct signed or unsigned product.
    always_comb begin
        a_ext_s    = {{DATA_WIDTH{signed_mode & a[DATA_WIDTH-1]}}, a};
        b_ext_s    = {{DATA_WIDTH{signed_mode & b[DATA_WIDTH-1]}}, b};
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = {{(ACC_WIDTH - PW){signed_mode & prod_s[PW-1]}}, prod_s};
    end

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext_s;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/matmul_tile_engine.sv
// Streaming tile engine: C_tile += A_col x B_row over k_len beats, then
// drains the M_BLOCK x N_BLOCK tile one row per res handshake.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   start, k_len, signed_mode,
//   accumulate                     : task request, sampled only in IDLE
//   a_valid/a_ready/a_data         : A column beat (M_BLOCK elements)
//   b_valid/b_ready/b_data         : B row beat (N_BLOCK elements)
//   res_valid/res_ready/res_data   : result row (N_BLOCK ACC_WIDTH elements)
//   res_last                       : marks row M_BLOCK-1
//   busy                           : engine not idle
//   done                           : one-cycle pulse after the last row
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M_BLOCK    = 3,
    parameter int N_BLOCK    = 3,
    parameter int K_MAX      = 64,
    parameter int ACC_WIDTH  = matmul_pkg::acc_width(DATA_WIDTH, K_MAX)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(K_MAX+1)-1:0]     k_len,
    input  logic                           signed_mode,
    input  logic                           accumulate,
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic [M_BLOCK*DATA_WIDTH-1:0]  a_data,
    input  logic                           b_valid,
    output logic                           b_ready,
    input  logic [N_BLOCK*DATA_WIDTH-1:0]  b_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [N_BLOCK*ACC_WIDTH-1:0]   res_data,
    output logic                           res_last,
    output logic                           busy,
    output logic                           done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = (M_BLOCK > 1) ? $clog2(M_BLOCK) : 1;

    state_e               state_r;
    state_e               state_next_s;
    logic [KW-1:0]        k_len_r;
    logic [KW-1:0]        beat_r;
    logic [KW-1:0]        k_clamp_s;
    logic                 signed_r;
    logic [RW-1:0]        row_r;
    logic                 beat_s;
    logic                 row_fire_s;
    logic                 clr_s;
    logic                 last_row_s;
    logic [ACC_WIDTH-1:0] acc_s [M_BLOCK][N_BLOCK];

    // Next-state decode and the control strobes derived from registered state.
    always_comb begin
        k_clamp_s    = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        beat_s       = (state_r == ST_LOAD) && a_valid && b_valid;
        row_fire_s   = (state_r == ST_DRAIN) && res_ready;
        clr_s        = (state_r == ST_IDLE) && start && !accumulate;
        last_row_s   = (row_r == RW'(M_BLOCK - 1));
        // Each side is only ready when the other is valid: beats are joint.
        a_ready      = (state_r == ST_LOAD) && b_valid;
        b_ready      = (state_r == ST_LOAD) && a_valid;
        res_valid    = (state_r == ST_DRAIN);
        res_last     = (state_r == ST_DRAIN) && last_row_s;
        busy         = (state_r != ST_IDLE);
        done         = (state_r == ST_DONE);
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = (k_clamp_s == '0) ? ST_DRAIN : ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_s && ((beat_r + KW'(1)) == k_len_r)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (row_fire_s && last_row_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, task parameters latched at start, beat and row counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            k_len_r  <= '0;
            signed_r <= 1'b0;
            beat_r   <= '0;
            row_r    <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && start) begin
                k_len_r  <= k_clamp_s;
                signed_r <= signed_mode;
                beat_r   <= '0;
                row_r    <= '0;
            end else begin
                if (beat_s) begin
                    beat_r <= beat_r + KW'(1);
                end else begin
                    beat_r <= beat_r;
                end
                if (row_fire_s) begin
                    row_r <= last_row_s ? '0 : (row_r + RW'(1));
                end else begin
                    row_r <= row_r;
                end
            end
        end
    end

    // Row mux from registered accumulators and row index; zero outside DRAIN.
    always_comb begin
        res_data = '0;
        for (int i = 0; i < M_BLOCK; i++) begin
            for (int j = 0; j < N_BLOCK; j++) begin
                res_data[j*ACC_WIDTH +: ACC_WIDTH] = res_data[j*ACC_WIDTH +: ACC_WIDTH] |
                    (((state_r == ST_DRAIN) && (row_r == RW'(i))) ? acc_s[i][j] : '0);
            end
        end
    end

    for (genvar gi = 0; gi < M_BLOCK; gi++) begin : g_row
        for (genvar gj = 0; gj < N_BLOCK; gj++) begin : g_col
            mac_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_mac (
                .clk         (clk),
                .rst         (rst),
                .clr         (clr_s),
                .en          (beat_s),
                .signed_mode (signed_r),
                .a           (a_data[elem_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .b           (b_data[elem_lsb(gj, DATA_WIDTH) +: DATA_WIDTH]),
                .acc         (acc_s[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Self-checking bench for matmul_tile_engine: directed and randomized tasks
// compared against a plain-arithmetic outer-product model.
module tb_matmul_tile_engine;

    localparam int DW   = 16;
    localparam int M    = 3;
    localparam int N    = 3;
    localparam int KMAX = 64;
    localparam int AW   = 2 * DW + $clog2(KMAX);
    localparam int KW   = $clog2(KMAX + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            signed_mode;
    logic            accumulate;
    logic            a_valid;
    logic            a_ready;
    logic [M*DW-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [N*DW-1:0] b_data;
    logic            res_valid;
    logic            res_ready;
    logic [N*AW-1:0] res_data;
    logic            res_last;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    matmul_tile_engine #(
        .DATA_WIDTH (DW),
        .M_BLOCK    (M),
        .N_BLOCK    (N),
        .K_MAX      (KMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .accumulate  (accumulate),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_data      (b_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    // Operand beats for the current task and the reference tile.
    logic [DW-1:0] ta  [80][M];
    logic [DW-1:0] tbv [80][N];
    longint        ref_acc [M][N];

    // Observations collected by the driver for one task.
    logic [AW-1:0] got_row [M][N];
    logic          got_last [M];
    int            fires, viol, unstable, rows, held, done_cyc, first_rv, last_fire;
    bit            timed_out, done_once;

    function automatic longint ext(input logic [DW-1:0] v, input bit sm);
        if (sm) return longint'($signed(v));
        else    return longint'({48'd0, v});
    endfunction

    // Reference: C = (accm ? C : 0) + sum over consumed beats of a x b.
    task automatic model_task(input int k, input bit sm, input bit accm);
        int nb;
        nb = (k > KMAX) ? KMAX : k;
        if (!accm) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) ref_acc[i][j] = 0;
        end
        for (int t = 0; t < nb; t++)
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    ref_acc[i][j] += ext(ta[t][i], sm) * ext(tbv[t][j], sm);
    endtask

    task automatic fill_random();
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < M; i++) ta[t][i] = DW'($urandom);
            for (int j = 0; j < N; j++) tbv[t][j] = DW'($urandom);
        end
    endtask

    // Drives one task and records what the DUT did; no judgement here.
    task automatic do_task(input int k, input bit sm, input bit accm,
                           input bit stall, input bit dstall, input bit spur);
        logic [N*AW-1:0] stall_data;
        bit stall_seen, prev_rv;
        int idx;
        @(negedge clk);
        start = 1'b1; k_len = KW'(k); signed_mode = sm; accumulate = accm;
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        fires = 0; viol = 0; unstable = 0; rows = 0; held = 0;
        done_cyc = -1; first_rv = -1; last_fire = -1; timed_out = 1'b0;
        stall_seen = 1'b0; prev_rv = 1'b0; stall_data = '0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            start = spur && (cyc == 2);
            if (spur && (cyc == 2)) k_len = KW'(5);
            a_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            b_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            idx = (fires < 80) ? fires : 79;
            for (int i = 0; i < M; i++) a_data[i*DW +: DW] = ta[idx][i];
            for (int j = 0; j < N; j++) b_data[j*DW +: DW] = tbv[idx][j];
            res_ready = !(dstall && rows == 1 && prev_rv && held < 5);
            if (!res_ready) held++;
            #1;
            if (a_ready && !b_valid) viol++;
            if (b_ready && !a_valid) viol++;
            if (a_valid && b_valid && a_ready && b_ready) begin
                fires++;
                last_fire = cyc;
            end
            prev_rv = res_valid;
            if (res_valid) begin
                if (first_rv < 0) first_rv = cyc;
                if (stall_seen && res_data !== stall_data) unstable++;
                if (!res_ready) begin
                    stall_data = res_data;
                    stall_seen = 1'b1;
                end else begin
                    stall_seen = 1'b0;
                    if (rows < M) begin
                        for (int j = 0; j < N; j++) got_row[rows][j] = res_data[j*AW +: AW];
                        got_last[rows] = res_last;
                    end
                    rows++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) timed_out = 1'b1;
        @(negedge clk);
        start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        #1;
        done_once = !done && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; accumulate = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1; a_data = '0; b_data = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({a_ready, b_ready, res_valid, res_last, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {a_ready, b_ready, res_valid, res_last, busy, done});
        end
        checks++;
        if (res_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %0h exp 0", res_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready, busy} !== 3'b0) begin
            errors++;
            $display("FAIL idle_ready got %b exp 000", {a_ready, b_ready, busy});
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) ref_acc[i][j] = 0;
    endtask

    task automatic test_identity();
        int exp_id [M][N];
        exp_id = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < M; i++) ta[t][i] = (i == t) ? 16'd1 : 16'd0;
            for (int j = 0; j < N; j++) tbv[t][j] = DW'(3 * t + j + 1);
        end
        do_task(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_task(3, 1'b0, 1'b0);
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[i][j] !== AW'(exp_id[i][j])) begin
                    errors++;
                    $display("FAIL identity_c%0d%0d got %0d exp %0d", i, j, got_row[i][j], exp_id[i][j]);
                end
            end
            checks++;
            if (got_last[i] !== (i == M - 1)) begin
                errors++;
                $display("FAIL identity_last%0d got %b exp %b", i, got_last[i], (i == M - 1));
            end
        end
        checks++;
        if (done_cyc !== 3 + M + 1) begin
            errors++;
            $display("FAIL identity_latency got %0d exp %0d", done_cyc, 3 + M + 1);
        end
        checks++;
        if (first_rv - last_fire !== 1) begin
            errors++;
            $display("FAIL identity_rv_delay got %0d exp 1", first_rv - last_fire);
        end
        checks++;
        if (done_once !== 1'b1) begin
            errors++;
            $display("FAIL identity_done_pulse got %b exp 1", done_once);
        end
    endtask

    task automatic test_signed();
        int exp_s [M][N];
        exp_s = '{'{-10, 2, -14}, '{15, -3, 21}, '{0, 0, 0}};
        ta[0][0] = 16'hFFFE; ta[0][1] = 16'd3; ta[0][2] = 16'd0;
        tbv[0][0] = 16'd5; tbv[0][1] = 16'hFFFF; tbv[0][2] = 16'd7;
        do_task(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_task(1, 1'b1, 1'b0);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[i][j] !== AW'(exp_s[i][j])) begin
                    errors++;
                    $display("FAIL signed_c%0d%0d got %0h exp %0h", i, j, got_row[i][j], AW'(exp_s[i][j]));
                end
            end
        do_task(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_task(1, 1'b0, 1'b0);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[i][j] !== AW'(ref_acc[i][j])) begin
                    errors++;
                    $display("FAIL unsigned_c%0d%0d got %0h exp %0h", i, j, got_row[i][j], AW'(ref_acc[i][j]));
                end
            end
    endtask

    task automatic test_kblock();
        int exp_v [3];
        bit accs [3];
        int ks [3];
        exp_v = '{2, 4, 1}; accs = '{1'b0, 1'b1, 1'b0}; ks = '{2, 2, 1};
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < M; i++) ta[t][i] = 16'd1;
            for (int j = 0; j < N; j++) tbv[t][j] = 16'd1;
        end
        for (int p = 0; p < 3; p++) begin
            do_task(ks[p], 1'b0, accs[p], 1'b0, 1'b0, 1'b0);
            model_task(ks[p], 1'b0, accs[p]);
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (got_row[i][j] !== AW'(exp_v[p])) begin
                        errors++;
                        $display("FAIL kblock%0d_c%0d%0d got %0d exp %0d", p, i, j, got_row[i][j], exp_v[p]);
                    end
                end
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] stalled [M][N];
        fill_random();
        do_task(6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        model_task(6, 1'b1, 1'b0);
        stalled = got_row;
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL stall_lone_ready got %0d exp 0", viol);
        end
        checks++;
        if (fires !== 6) begin
            errors++;
            $display("FAIL stall_beats got %0d exp 6", fires);
        end
        checks++;
        if (unstable !== 0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got unstable=%0d timeout=%0d exp 0/0", unstable, timed_out);
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (stalled[i][j] !== AW'(ref_acc[i][j])) begin
                    errors++;
                    $display("FAIL stall_c%0d%0d got %0h exp %0h", i, j, stalled[i][j], AW'(ref_acc[i][j]));
                end
            end
        do_task(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_task(6, 1'b1, 1'b0);
        checks++;
        if (got_row !== stalled) begin
            errors++;
            $display("FAIL stall_vs_unstalled got %0h exp %0h", got_row[0][0], stalled[0][0]);
        end
    endtask

    task automatic test_edge();
        // k_len = 0 with accumulate: drain what is held.
        do_task(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_task(0, 1'b0, 1'b1);
        checks++;
        if (first_rv !== 1 || fires !== 0) begin
            errors++;
            $display("FAIL k0_drain got rv=%0d beats=%0d exp 1/0", first_rv, fires);
        end
        for (int i = 0; i < M; i++) begin
            checks++;
            if (got_row[i][1] !== AW'(ref_acc[i][1])) begin
                errors++;
                $display("FAIL k0_c%0d1 got %0h exp %0h", i, got_row[i][1], AW'(ref_acc[i][1]));
            end
        end
        // Over-long request is clamped.
        fill_random();
        do_task(KMAX + 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_task(KMAX + 5, 1'b0, 1'b0);
        checks++;
        if (fires !== KMAX) begin
            errors++;
            $display("FAIL clamp_beats got %0d exp %0d", fires, KMAX);
        end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (got_row[M-1][j] !== AW'(ref_acc[M-1][j])) begin
                errors++;
                $display("FAIL clamp_c2%0d got %0h exp %0h", j, got_row[M-1][j], AW'(ref_acc[M-1][j]));
            end
        end
        // A start pulse during LOAD must not restart or resize the task.
        fill_random();
        do_task(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        model_task(4, 1'b1, 1'b0);
        checks++;
        if (fires !== 4 || done_cyc !== 4 + M + 1) begin
            errors++;
            $display("FAIL spur_start got beats=%0d done=%0d exp 4/%0d", fires, done_cyc, 4 + M + 1);
        end
        for (int i = 0; i < M; i++) begin
            checks++;
            if (got_row[i][0] !== AW'(ref_acc[i][0])) begin
                errors++;
                $display("FAIL spur_c%0d0 got %0h exp %0h", i, got_row[i][0], AW'(ref_acc[i][0]));
            end
        end
    endtask

    task automatic test_rst_mid();
        int late_done;
        fill_random();
        @(negedge clk);
        start = 1'b1; k_len = KW'(3); signed_mode = 1'b0; accumulate = 1'b0;
        @(negedge clk);
        start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < M; i++) a_data[i*DW +: DW] = ta[0][i];
        for (int j = 0; j < N; j++) b_data[j*DW +: DW] = tbv[0][j];
        @(negedge clk);
        for (int i = 0; i < M; i++) a_data[i*DW +: DW] = ta[1][i];
        for (int j = 0; j < N; j++) b_data[j*DW +: DW] = tbv[1][j];
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready, res_valid, res_last, busy, done} !== 6'b0 || res_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b exp 000000", {a_ready, b_ready, res_valid, res_last, busy, done});
        end
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        late_done = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got %0d exp 0", late_done);
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) ref_acc[i][j] = 0;
        fill_random();
        // accumulate=1 exposes any accumulator state that survived reset.
        do_task(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_task(1, 1'b0, 1'b1);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_row[i][j] !== AW'(ref_acc[i][j])) begin
                    errors++;
                    $display("FAIL rst_fresh_c%0d%0d got %0h exp %0h", i, j, got_row[i][j], AW'(ref_acc[i][j]));
                end
            end
    endtask

    task automatic test_random();
        int k;
        bit sm, accm, st;
        for (int r = 0; r < 6; r++) begin
            fill_random();
            k = $urandom_range(1, 10);
            sm = 1'($urandom_range(0, 1));
            accm = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            do_task(k, sm, accm, st, st, 1'b0);
            model_task(k, sm, accm);
            checks++;
            if (fires !== k || timed_out !== 1'b0 || done_once !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_flow got beats=%0d to=%0d done1=%0d exp %0d/0/1", r, fires, timed_out, done_once, k);
            end
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (got_row[i][j] !== AW'(ref_acc[i][j])) begin
                        errors++;
                        $display("FAIL rand%0d_c%0d%0d got %0h exp %0h", r, i, j, got_row[i][j], AW'(ref_acc[i][j]));
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_kblock();
        test_stall();
        test_edge();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
